// File: rtl/led_step_ctrl_if.sv
// Switch inputs and step/setting outputs shared by the control stage and the LED register stage.
interface led_step_ctrl_if;
    logic [3:0] sw;
    logic       step;
    logic [1:0] speed;
    logic [1:0] mode;
    logic       mode_chg;

    modport master (input sw, output step, speed, mode, mode_chg);
    modport slave  (output sw, input step, speed, mode, mode_chg);
endinterface

// File: rtl/led_step_ctrl.sv
// Switch synchronise/debounce, speed/mode decode and one-cycle step enable for the LED effects.
// Optional LED_STEP_MODECHG_EN: mode changes also restart the step cadence and pulse mode_chg.
module led_step_ctrl #(
    parameter int DEB_CYCLES = 250000,
    parameter int BASE_DIV   = 12500000,
    parameter int CW         = 32
) (
    input logic             clk,
    input logic             reset,
    led_step_ctrl_if.master bus
);
    typedef enum logic [1:0] {WARMUP, RUN, RESTART} state_t;

    localparam logic [CW-1:0] DEB_LAST  = CW'(DEB_CYCLES - 1);
    localparam logic [CW-1:0] WARM_LAST = CW'(DEB_CYCLES + 1);
    localparam logic [CW-1:0] ONE       = CW'(1);

    state_t        state, state_next;
    logic [3:0]    sync1, sync2;
    logic [3:0]    deb, deb_next;
    logic [CW-1:0] deb_cnt      [4];
    logic [CW-1:0] deb_cnt_next [4];
    logic [CW-1:0] warm_cnt, warm_cnt_next;
    logic [CW-1:0] presc, presc_next;
    logic [CW-1:0] period;
    logic          speed_upd;
    logic          restart_req;
    logic          step_int;
`ifdef LED_STEP_MODECHG_EN
    logic          mode_upd;
    logic          mode_chg_q, mode_chg_next;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= bus.sw;
            sync2 <= sync1;
        end
    end

    // A bit only moves once it has disagreed with the debounced value for DEB_CYCLES edges in a row.
    always_comb begin
        deb_next = deb;
        for (int b = 0; b < 4; b++) begin
            deb_cnt_next[b] = '0;
            if (sync2[b] != deb[b]) begin
                if (deb_cnt[b] == DEB_LAST) begin
                    deb_next[b] = sync2[b];
                end else begin
                    deb_cnt_next[b] = deb_cnt[b] + ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            deb <= '0;
            for (int b = 0; b < 4; b++) begin
                deb_cnt[b] <= '0;
            end
        end else begin
            deb <= deb_next;
            for (int b = 0; b < 4; b++) begin
                deb_cnt[b] <= deb_cnt_next[b];
            end
        end
    end

    assign speed_upd = (deb_next[1:0] != deb[1:0]);
`ifdef LED_STEP_MODECHG_EN
    assign mode_upd    = (deb_next[3:2] != deb[3:2]);
    assign restart_req = speed_upd | mode_upd;
`else
    assign restart_req = speed_upd;
`endif

    assign period = CW'(BASE_DIV) << deb[1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= WARMUP;
            warm_cnt <= '0;
            presc    <= '0;
        end else begin
            state    <= state_next;
            warm_cnt <= warm_cnt_next;
            presc    <= presc_next;
        end
    end

    // The step that coincides with a settings update still fires with the old period.
    always_comb begin
        state_next    = state;
        warm_cnt_next = warm_cnt;
        presc_next    = '0;
        step_int      = 1'b0;
        case (state)
            WARMUP: begin
                if (warm_cnt == WARM_LAST) begin
                    state_next    = RUN;
                    warm_cnt_next = '0;
                end else begin
                    warm_cnt_next = warm_cnt + ONE;
                end
            end
            RUN: begin
                step_int = (presc == period - ONE);
                if (restart_req) begin
                    state_next = RESTART;
                end else if (!step_int) begin
                    presc_next = presc + ONE;
                end
            end
            RESTART: begin
                state_next = restart_req ? RESTART : RUN;
            end
            default: begin
                state_next = WARMUP;
            end
        endcase
    end

`ifdef LED_STEP_MODECHG_EN
    assign mode_chg_next = (state_next == RESTART) && mode_upd;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode_chg_q <= 1'b0;
        end else begin
            mode_chg_q <= mode_chg_next;
        end
    end

    assign bus.mode_chg = mode_chg_q;
`else
    assign bus.mode_chg = 1'b0;
`endif

    assign bus.step  = step_int;
    assign bus.speed = deb[1:0];
    assign bus.mode  = deb[3:2];
endmodule

// File: tb/tb_led_step_ctrl.sv
// Randomised scoreboard bench for led_step_ctrl; the reference uses debounce windows and period phase arithmetic.
module tb_led_step_ctrl;
    localparam int DEB  = 4;
    localparam int BASE = 5;
    localparam int MULT [4] = '{1, 2, 4, 8};
`ifdef LED_STEP_MODECHG_EN
    localparam bit MODECHG = 1'b1;
`else
    localparam bit MODECHG = 1'b0;
`endif

    typedef struct packed {
        int         n;
        logic       step;
        logic [1:0] speed;
        logic [1:0] mode;
        logic       mode_chg;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    led_step_ctrl_if bus ();

    led_step_ctrl #(
        .DEB_CYCLES(DEB),
        .BASE_DIV  (BASE),
        .CW        (32)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int         vectors     = 0;
    int         miscompares = 0;
    exp_t       exp_q [$];
    logic [3:0] sw_hist [$];
    logic [3:0] ref_deb   = 4'h0;
    logic [3:0] cur_sw    = 4'h0;
    int         n         = 0;
    int         run_start = DEB + 2;
    bit         active    = 1'b0;

    function automatic int period_of(input logic [1:0] s);
        return BASE * MULT[s];
    endfunction

    // Value the debouncer sees at edge m: switches pass two flops, so they lag three intervals.
    function automatic logic [3:0] seen_at(input int m);
        if (m < 3) return 4'h0;
        return sw_hist[m - 3];
    endfunction

    task automatic checkOutput(input string name, input int got, input int want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("[TB] FAIL %s @interval %0d: got %0d, expected %0d", name, n, got, want);
        end
    endtask

    // Reference for edge n: a bit flips when its last DEB seen samples all disagree with it.
    task automatic model_edge();
        logic [3:0] new_deb;
        logic [3:0] s;
        bit         flip;
        bit         spd_chg;
        bit         mode_chg;
        bit         restart_now;
        int         p;
        exp_t       e;
        new_deb = ref_deb;
        for (int b = 0; b < 4; b++) begin
            flip = (n >= DEB);
            for (int k = 0; k < DEB; k++) begin
                s = seen_at(n - k);
                if (n - k >= 1 && s[b] == ref_deb[b]) flip = 1'b0;
            end
            if (flip) new_deb[b] = ~ref_deb[b];
        end
        spd_chg     = (new_deb[1:0] != ref_deb[1:0]);
        mode_chg    = (new_deb[3:2] != ref_deb[3:2]);
        ref_deb     = new_deb;
        restart_now = (n > DEB + 2) && (spd_chg || (MODECHG && mode_chg));
        if (restart_now) run_start = n + 1;
        p          = period_of(ref_deb[1:0]);
        e.n        = n;
        e.speed    = ref_deb[1:0];
        e.mode     = ref_deb[3:2];
        e.mode_chg = restart_now && MODECHG && mode_chg;
        e.step     = (n >= run_start) && (((n - run_start) % p) == p - 1);
        exp_q.push_back(e);
    endtask

    task automatic applyStimulus(input logic [3:0] v, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            n++;
            model_edge();
            bus.sw = v;
            cur_sw = v;
            sw_hist.push_back(v);
        end
    endtask

    task automatic release_reset(input logic [3:0] v);
        exp_t e;
        @(posedge clk);
        #1;
        exp_q.delete();
        sw_hist.delete();
        n         = 0;
        run_start = DEB + 2;
        ref_deb   = 4'h0;
        reset     = 1'b1;
        bus.sw    = v;
        cur_sw    = v;
        sw_hist.push_back(v);
        e.n        = 0;
        e.step     = 1'b0;
        e.speed    = 2'd0;
        e.mode     = 2'd0;
        e.mode_chg = 1'b0;
        exp_q.push_back(e);
        active = 1'b1;
    endtask

    task automatic assert_reset();
        reset  = 1'b0;
        active = 1'b0;
        exp_q.delete();
        #1;
        checkOutput("reset step", int'(bus.step), 0);
        checkOutput("reset speed", int'(bus.speed), 0);
        checkOutput("reset mode", int'(bus.mode), 0);
        checkOutput("reset mode_chg", int'(bus.mode_chg), 0);
    endtask

    // Hold the current switches until interval n+1+ahead sits at the requested prescaler phase.
    task automatic hold_until_phase(input int ahead, input int phase);
        int guard;
        int t;
        guard = 0;
        t     = n + 1 + ahead;
        while (!(t >= run_start && ((t - run_start) % period_of(ref_deb[1:0])) == phase)) begin
            applyStimulus(cur_sw, 1);
            t = n + 1 + ahead;
            guard++;
            if (guard > 400) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL phase align: got no alignment in %0d cycles, expected phase %0d", guard, phase);
                return;
            end
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (active) begin
            while (exp_q.size() > 0 && exp_q[0].n < n) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL stale expectation: got interval %0d, expected %0d", n, exp_q[0].n);
                void'(exp_q.pop_front());
            end
            if (exp_q.size() > 0 && exp_q[0].n == n) begin
                e = exp_q.pop_front();
                checkOutput("step", int'(bus.step), int'(e.step));
                checkOutput("speed", int'(bus.speed), int'(e.speed));
                checkOutput("mode", int'(bus.mode), int'(e.mode));
                checkOutput("mode_chg", int'(bus.mode_chg), int'(e.mode_chg));
            end else begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL scoreboard empty @interval %0d: got step %0d, expected an entry", n, bus.step);
            end
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: got no end of run, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int len;
        logic [3:0] v;
        bus.sw = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("por step", int'(bus.step), 0);
        checkOutput("por speed", int'(bus.speed), 0);
        checkOutput("por mode", int'(bus.mode), 0);
        checkOutput("por mode_chg", int'(bus.mode_chg), 0);

        release_reset(4'h0);
        applyStimulus(4'h0, 30);
        applyStimulus(4'h2, 70);
        applyStimulus(4'h0, 30);
        applyStimulus(4'h1, 3);
        applyStimulus(4'h0, 30);
        applyStimulus(4'hC, 40);

        hold_until_phase(DEB + 1, period_of(ref_deb[1:0]) - 1);
        applyStimulus(4'hD, 50);

        applyStimulus(4'hF, 100);
        hold_until_phase(DEB + 1, 30);
        applyStimulus(4'hC, 40);

        for (int i = 0; i < 40; i++) begin
            v   = 4'($urandom_range(0, 15));
            len = $urandom_range(1, 14);
            applyStimulus(v, len);
        end

        applyStimulus(4'h3, 100);
        hold_until_phase(-1, 3);
        assert_reset();
        repeat (2) @(posedge clk);
        release_reset(4'h3);
        applyStimulus(4'h3, 60);

        for (int i = 0; i < 20; i++) begin
            v   = 4'($urandom_range(0, 15));
            len = $urandom_range(2, 30);
            applyStimulus(v, len);
        end
        applyStimulus(cur_sw, 50);

        @(posedge clk);
        #1;
        active = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
